service_counter_bank: RTL and testbench

SERVICE_COUNTER_BANK -- requirements
Module: service_counter_bank

---
 rtl/service_counter_bank.sv | 163 ++++++++++++++++
 tb/tb_service_counter_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/service_counter_bank.sv
// Three-lane service counter bank. Each lane takes a customer from the
// dispatcher, counts its service time down on tick strobes and pulses done
// when finished. A shared counter totals completions, saturating at 255.

package scb_pkg;
  localparam int VEC_W = 4;

  typedef struct packed {
    logic             ld;
    logic [VEC_W-1:0] dn;
    logic [VEC_W-1:0] dt;
  } lane_req_t;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             err;
    logic [VEC_W-1:0] cur;
    logic [VEC_W-1:0] rem;
  } lane_rsp_t;
endpackage

// One service lane: IDLE -> SERVE -> DONE -> IDLE (or IDLE -> DONE for dt=0).
module scb_lane
  import scb_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tick,
  input  lane_req_t req,
  output lane_rsp_t rsp
);
  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  state_t           state, state_nx;
  logic [VEC_W-1:0] cur, cur_nx;
  logic [VEC_W-1:0] rem, rem_nx;
  logic             err, err_nx;

  // State, customer, remaining time and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= '0;
      rem   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
      rem   <= rem_nx;
      err   <= err_nx;
    end
  end

  // Next state; a load outside IDLE is dropped and flagged
  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    rem_nx   = rem;
    err_nx   = err;
    case (state)
      IDLE: begin
        // A same-cycle tick is ignored here so service spans exactly dt ticks
        if (req.ld) begin
          cur_nx   = req.dn;
          rem_nx   = req.dt;
          state_nx = (req.dt != '0) ? SERVE : DONE;
        end
      end
      SERVE: begin
        if (req.ld) err_nx = 1'b1;
        if (tick) begin
          if (rem > VEC_W'(1)) begin
            rem_nx = rem - VEC_W'(1);
          end else begin
            rem_nx   = '0;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        if (req.ld) err_nx = 1'b1;
        state_nx = IDLE;
        cur_nx   = '0;
        rem_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // busy includes the incoming load so the dispatcher never double-books
  assign rsp = '{(state != IDLE) || req.ld, state == DONE, err, cur, rem};
endmodule

module service_counter_bank
  import scb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ld1,
  input  logic       ld2,
  input  logic       ld3,
  input  logic [3:0] dn1,
  input  logic [3:0] dn2,
  input  logic [3:0] dn3,
  input  logic [3:0] dt1,
  input  logic [3:0] dt2,
  input  logic [3:0] dt3,
  output logic [2:0] busy,
  output logic [3:0] cur1,
  output logic [3:0] cur2,
  output logic [3:0] cur3,
  output logic [3:0] rem1,
  output logic [3:0] rem2,
  output logic [3:0] rem3,
  output logic [2:0] done,
  output logic [7:0] served,
  output logic [2:0] err
);
  localparam int NUM_LANES = 3;

  lane_req_t [NUM_LANES-1:0] req;
  lane_rsp_t [NUM_LANES-1:0] rsp;
  logic      [1:0]           n_done;
  logic      [8:0]           served_sum;

  assign req[0] = '{ld1, dn1, dt1};
  assign req[1] = '{ld2, dn2, dt2};
  assign req[2] = '{ld3, dn3, dt3};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    scb_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .req  (req[g]),
      .rsp  (rsp[g])
    );
    assign busy[g] = rsp[g].busy;
    assign done[g] = rsp[g].done;
    assign err[g]  = rsp[g].err;
  end

  assign cur1 = rsp[0].cur;
  assign cur2 = rsp[1].cur;
  assign cur3 = rsp[2].cur;
  assign rem1 = rsp[0].rem;
  assign rem2 = rsp[1].rem;
  assign rem3 = rsp[2].rem;

  // Completions this cycle and the unsaturated running total
  always_comb begin
    n_done     = 2'(done[0]) + 2'(done[1]) + 2'(done[2]);
    served_sum = {1'b0, served} + 9'(n_done);
  end

  // Saturating completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) served <= '0;
    else        served <= served_sum[8] ? 8'hFF : served_sum[7:0];
  end
endmodule

// File: tb/tb_service_counter_bank.sv
// Directed bench for service_counter_bank with a customer-level reference
// model compared on every falling clock edge.
module tb_service_counter_bank;
  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic       ld1 = 1'b0, ld2 = 1'b0, ld3 = 1'b0;
  logic [3:0] dn1 = '0, dn2 = '0, dn3 = '0;
  logic [3:0] dt1 = '0, dt2 = '0, dt3 = '0;
  logic [2:0] busy, done, err;
  logic [3:0] cur1, cur2, cur3, rem1, rem2, rem3;
  logic [7:0] served;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  service_counter_bank dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .ld1(ld1), .ld2(ld2), .ld3(ld3),
    .dn1(dn1), .dn2(dn2), .dn3(dn3),
    .dt1(dt1), .dt2(dt2), .dt3(dt3),
    .busy(busy), .cur1(cur1), .cur2(cur2), .cur3(cur3),
    .rem1(rem1), .rem2(rem2), .rem3(rem3),
    .done(done), .served(served), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a lane holds a customer with some ticks still owed;
  // once nothing is owed it shows done for a cycle and is then released.
  bit m_act[3];
  int m_cur[3], m_left[3];
  bit m_err[3];
  int m_served;

  always @(posedge clk or negedge rst_n) begin
    bit ldv[3];
    int dnv[3], dtv[3];
    int nd;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] = 0; m_cur[i] = 0; m_left[i] = 0; m_err[i] = 0;
      end
      m_served = 0;
    end else begin
      ldv = '{ld1, ld2, ld3};
      dnv = '{int'(dn1), int'(dn2), int'(dn3)};
      dtv = '{int'(dt1), int'(dt2), int'(dt3)};
      nd = 0;
      for (int i = 0; i < 3; i++) begin
        if (m_act[i] && m_left[i] == 0) begin
          nd++;
          m_act[i] = 0; m_cur[i] = 0;
          if (ldv[i]) m_err[i] = 1;
        end else if (m_act[i]) begin
          if (tick) m_left[i]--;
          if (ldv[i]) m_err[i] = 1;
        end else if (ldv[i]) begin
          m_act[i] = 1; m_cur[i] = dnv[i]; m_left[i] = dtv[i];
        end
      end
      m_served = (m_served + nd > 255) ? 255 : m_served + nd;
    end
  end

  logic [3:0] d_cur[3], d_rem[3];
  logic       d_ld[3];
  assign d_cur[0] = cur1; assign d_cur[1] = cur2; assign d_cur[2] = cur3;
  assign d_rem[0] = rem1; assign d_rem[1] = rem2; assign d_rem[2] = rem3;
  assign d_ld[0]  = ld1;  assign d_ld[1]  = ld2;  assign d_ld[2]  = ld3;

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_act[i] | d_ld[i]));
      chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_act[i] && m_left[i] == 0));
      chk($sformatf("err[%0d]", i),  32'(err[i]),  32'(m_err[i]));
      chk($sformatf("cur%0d", i+1),  32'(d_cur[i]), m_act[i] ? m_cur[i] : 0);
      chk($sformatf("rem%0d", i+1),  32'(d_rem[i]), m_act[i] ? m_left[i] : 0);
    end
    chk("served", 32'(served), m_served);
  end

  task automatic tk();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int guard;
    int n;
    // Reset state
    #3;
    chk("rst_served", served, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur1", cur1, 0);
    #4 rst_n = 1'b1;
    tk();

    // Basic service with load and tick coinciding
    ld1 = 1; dn1 = 5; dt1 = 3; tick = 1;
    #1 chk("s1_busy_same_cycle", busy[0], 1);
    tk(); ld1 = 0;
    chk("s1_cur", cur1, 5); chk("s1_rem3", rem1, 3);
    tk(); chk("s1_rem2", rem1, 2);
    tk(); chk("s1_rem1", rem1, 1);
    tk(); chk("s1_rem0", rem1, 0); chk("s1_done", done, 3'b001); chk("s1_cur_done", cur1, 5);
    tk(); chk("s1_done_off", done, 0); chk("s1_cur_clr", cur1, 0);
    chk("s1_served", served, 1); chk("s1_busy_off", busy[0], 0);

    // Tick gating: tick only every 4th cycle
    tick = 0; ld2 = 1; dn2 = 3; dt2 = 2;
    tk(); ld2 = 0;
    chk("s2_cur", cur2, 3); chk("s2_rem_load", rem2, 2);
    for (int i = 0; i < 12; i++) begin
      tick = (i % 4 == 3);
      tk();
      chk($sformatf("s2_rem_i%0d", i), rem2, (i < 3) ? 2 : (i < 7) ? 1 : 0);
      chk($sformatf("s2_done_i%0d", i), done[1], (i == 7) ? 1 : 0);
    end
    tick = 0;
    chk("s2_served", served, 2);

    // Zero service time
    ld3 = 1; dn3 = 9; dt3 = 0;
    tk(); ld3 = 0;
    chk("s3_done", done, 3'b100); chk("s3_cur", cur3, 9);
    tk(); chk("s3_done_off", done, 0); chk("s3_cur_clr", cur3, 0);
    chk("s3_served", served, 3);

    // Overrun while serving
    tick = 1; ld1 = 1; dn1 = 2; dt1 = 6;
    tk(); ld1 = 0; chk("s4_rem6", rem1, 6);
    tk(); tk(); chk("s4_rem4", rem1, 4);
    ld1 = 1; dn1 = 7; dt1 = 9; tick = 0;
    tk(); ld1 = 0;
    chk("s4_cur_kept", cur1, 2); chk("s4_rem_kept", rem1, 4); chk("s4_err", err, 3'b001);
    tick = 1;
    repeat (4) tk();
    chk("s4_done", done, 3'b001);
    tk(); tick = 0;
    chk("s4_err_sticky", err[0], 1); chk("s4_served", served, 4);

    // Fill served up to 254 with zero-time customers
    guard = 0;
    dn1 = 1; dn2 = 2; dn3 = 3; dt1 = 0; dt2 = 0; dt3 = 0;
    while (m_served < 254 && guard < 300) begin
      n = 254 - m_served;
      ld1 = 1; ld2 = (n >= 2); ld3 = (n >= 3);
      tk(); ld1 = 0; ld2 = 0; ld3 = 0;
      tk();
      guard++;
    end
    if (guard >= 300) chk("s5_fill_timeout", guard, 0);
    chk("s5_preset", served, 254);

    // Simultaneous completion into saturation
    tick = 1; ld1 = 1; ld2 = 1; ld3 = 1; dt1 = 1; dt2 = 1; dt3 = 1;
    tk(); ld1 = 0; ld2 = 0; ld3 = 0;
    chk("s5_rem", {rem3, rem2, rem1}, 12'h111);
    tk(); chk("s5_done_all", done, 3'b111);
    tk(); chk("s5_sat", served, 255);
    ld1 = 1; dt1 = 0;
    tk(); ld1 = 0;
    tk(); chk("s5_sat_hold", served, 255);

    // Asynchronous reset mid-service
    ld2 = 1; dn2 = 4; dt2 = 3;
    tk(); ld2 = 0; chk("s6_rem3", rem2, 3);
    tk(); chk("s6_rem2", rem2, 2);
    #1 rst_n = 0; ld3 = 1;
    #1;
    chk("s6_rem_clr", rem2, 0); chk("s6_cur_clr", cur2, 0);
    chk("s6_done", done, 0); chk("s6_served", served, 0);
    chk("s6_err", err, 0); chk("s6_busy_ld", busy, 3'b100);
    #3 ld3 = 0; rst_n = 1;
    tk(); chk("s6_no_done", done, 0); chk("s6_served_hold", served, 0);
    ld2 = 1; dn2 = 6; dt2 = 1;
    tk(); ld2 = 0;
    chk("s6_cur_new", cur2, 6); chk("s6_rem_new", rem2, 1);
    tk(); chk("s6_done_new", done, 3'b010);
    tk(); chk("s6_served_new", served, 1);

    repeat (2) tk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
